// File: rtl/clock_ctrl_pkg.sv
// Shared encodings and types for the clock user-interface controller.
// Mode encodings match the mode input of the Time counter chain.
package clock_ctrl_pkg;

  localparam logic [1:0] MODE_RUN = 2'b00;
  localparam logic [1:0] MODE_SEC = 2'b01;
  localparam logic [1:0] MODE_MIN = 2'b10;
  localparam logic [1:0] MODE_HR  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN = MODE_RUN,
    ST_SEC = MODE_SEC,
    ST_MIN = MODE_MIN,
    ST_HR  = MODE_HR
  } state_t;

  typedef enum logic [1:0] {
    RPT_NONE  = 2'b00,
    RPT_PLUS  = 2'b01,
    RPT_MINUS = 2'b10
  } rpt_sel_t;

  // Counter width for a count limit n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic state_t next_state(input state_t s);
    case (s)
      ST_RUN:  return ST_SEC;
      ST_SEC:  return ST_MIN;
      ST_MIN:  return ST_HR;
      default: return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Synchronizes one raw board input and debounces it; press is a registered
// one-cycle strobe on each accepted 0->1 transition of the debounced level.
module btn_conditioner
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], raw};
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // The level moves only after DEBOUNCE consecutive disagreeing samples.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/clock_ctrl.sv
// Button/switch front end for the time-keeping block: sequences the set modes
// and produces plus/minus pulses with hold-to-repeat, enable and blink.
//
//   state  | meaning
//   ST_RUN | clock running (if run_sw), plus/minus ignored
//   ST_SEC | seconds field being set, time frozen
//   ST_MIN | minutes field being set, time frozen
//   ST_HR  | hours field being set, time frozen
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE     = 1_000_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int TIMEOUT      = 500_000_000,
  parameter int BLINK_HALF   = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       plus_btn,
  input  logic       minus_btn,
  input  logic       run_sw,
  output logic [1:0] mode,
  output logic       plus,
  output logic       minus,
  output logic       enable,
  output logic       blink
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = cnt_width(RPT_MAX);
  localparam int TW = cnt_width(TIMEOUT);
  localparam int BW = cnt_width(BLINK_HALF);

  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic mode_level_unused, mode_press;
  logic plus_level, plus_press;
  logic minus_level, minus_press;
  logic run_level, run_press;

  btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_mode_btn (
    .clk(clk), .reset(reset), .raw(mode_btn), .level(mode_level_unused), .press(mode_press)
  );
  btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_plus_btn (
    .clk(clk), .reset(reset), .raw(plus_btn), .level(plus_level), .press(plus_press)
  );
  btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_minus_btn (
    .clk(clk), .reset(reset), .raw(minus_btn), .level(minus_level), .press(minus_press)
  );
  btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_run_sw (
    .clk(clk), .reset(reset), .raw(run_sw), .level(run_level), .press(run_press)
  );

  state_t        state_q, state_d;
  rpt_sel_t      rpt_sel_q, rpt_sel_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_rate_q, rpt_rate_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          plus_q, plus_d;
  logic          minus_q, minus_d;
  logic          enable_q, enable_d;

  logic state_change;
  logic any_press;
  logic pulse;
  logic rpt_hold;
  logic rpt_hit;

  always_comb begin
    state_d      = state_q;
    rpt_sel_d    = rpt_sel_q;
    rpt_cnt_d    = rpt_cnt_q;
    rpt_rate_d   = rpt_rate_q;
    idle_d       = idle_q;
    blink_cnt_d  = blink_cnt_q;
    blink_d      = blink_q;
    plus_d       = 1'b0;
    minus_d      = 1'b0;
    any_press    = mode_press | plus_press | minus_press | run_press;
    rpt_hold     = ((rpt_sel_q == RPT_PLUS) && plus_level) ||
                   ((rpt_sel_q == RPT_MINUS) && minus_level);
    rpt_hit      = (rpt_cnt_q == (rpt_rate_q ? RATE_LAST : DELAY_LAST));

    if (mode_press) begin
      state_d = next_state(state_q);
    end else if ((state_q != ST_RUN) && (idle_q == IDLE_LAST)) begin
      state_d = ST_RUN;
    end
    state_change = (state_d != state_q);

    // A mode step or both buttons held cancels any repeat; it needs a fresh press.
    if ((state_d == ST_RUN) || state_change || (plus_level && minus_level)) begin
      rpt_sel_d  = RPT_NONE;
      rpt_cnt_d  = '0;
      rpt_rate_d = 1'b0;
    end else if (plus_press) begin
      plus_d     = 1'b1;
      rpt_sel_d  = RPT_PLUS;
      rpt_cnt_d  = '0;
      rpt_rate_d = 1'b0;
    end else if (minus_press) begin
      minus_d    = 1'b1;
      rpt_sel_d  = RPT_MINUS;
      rpt_cnt_d  = '0;
      rpt_rate_d = 1'b0;
    end else if (rpt_hold) begin
      if (rpt_hit) begin
        plus_d     = (rpt_sel_q == RPT_PLUS);
        minus_d    = (rpt_sel_q == RPT_MINUS);
        rpt_cnt_d  = '0;
        rpt_rate_d = 1'b1;
      end else if (rpt_cnt_q != '1) begin
        rpt_cnt_d = rpt_cnt_q + RW'(1);
      end
    end else begin
      rpt_sel_d  = RPT_NONE;
      rpt_cnt_d  = '0;
      rpt_rate_d = 1'b0;
    end

    pulse = plus_d | minus_d;

    if ((state_d == ST_RUN) || state_change || any_press || pulse) begin
      idle_d = '0;
    end else if (idle_q != '1) begin
      idle_d = idle_q + TW'(1);
    end

    // An edited field is shown immediately and stays up for a full half-period.
    if ((state_d == ST_RUN) || state_change || pulse) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end

    enable_d = run_level && (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      rpt_sel_q   <= RPT_NONE;
      rpt_cnt_q   <= '0;
      rpt_rate_q  <= 1'b0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      plus_q      <= 1'b0;
      minus_q     <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rpt_sel_q   <= rpt_sel_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_rate_q  <= rpt_rate_d;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      plus_q      <= plus_d;
      minus_q     <= minus_d;
      enable_q    <= enable_d;
    end
  end

  assign mode   = state_q;
  assign plus   = plus_q;
  assign minus  = minus_q;
  assign enable = enable_q;
  assign blink  = blink_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: directed scenarios plus random button activity, all
// outputs compared every cycle against a behavioural model of the controller.
module tb_clock_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int TO = 100;
  localparam int BH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode_btn, plus_btn, minus_btn, run_sw;
  logic [1:0] mode;
  logic       plus, minus, enable, blink;

  clock_ctrl #(
    .DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .plus_btn(plus_btn),
    .minus_btn(minus_btn), .run_sw(run_sw), .mode(mode), .plus(plus),
    .minus(minus), .enable(enable), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int plus_log[$];
  int minus_log[$];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model state. Input index: 0 mode, 1 plus, 2 minus, 3 run.
  int h1[4], h2[4], m_lvl[4], m_run[4], m_press[4];
  int m_mode, m_idle, m_plus, m_minus, m_enable, m_blink, m_bage, m_hold, m_hage;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      h1[i] = 0; h2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_press[i] = 0;
    end
    m_mode = 0; m_idle = 0; m_plus = 0; m_minus = 0; m_enable = 0;
    m_blink = 1; m_bage = 0; m_hold = 0; m_hage = 0;
  endtask

  task automatic model_step();
    int raw[4];
    int s, nmode, changed, pp, pn, anyp;
    raw[0] = int'(mode_btn); raw[1] = int'(plus_btn);
    raw[2] = int'(minus_btn); raw[3] = int'(run_sw);
    if (reset) begin
      model_reset();
      return;
    end
    nmode = m_mode;
    if (m_press[0] != 0) nmode = (m_mode + 1) % 4;
    else if (m_mode != 0 && m_idle == TO - 1) nmode = 0;
    changed = (nmode != m_mode);
    pp = 0; pn = 0;
    if (nmode == 0 || changed != 0 || (m_lvl[1] != 0 && m_lvl[2] != 0)) m_hold = 0;
    else if (m_press[1] != 0) begin pp = 1; m_hold = 1; m_hage = 0; end
    else if (m_press[2] != 0) begin pn = 1; m_hold = 2; m_hage = 0; end
    else if (m_hold != 0 && m_lvl[m_hold] != 0) begin
      m_hage++;
      if (m_hage == RD || (m_hage > RD && (m_hage - RD) % RR == 0)) begin
        pp = (m_hold == 1); pn = (m_hold == 2);
      end
    end else m_hold = 0;
    anyp = m_press[0] | m_press[1] | m_press[2] | m_press[3];
    if (nmode == 0 || changed != 0 || anyp != 0 || pp != 0 || pn != 0) m_idle = 0;
    else m_idle++;
    if (nmode == 0 || changed != 0 || pp != 0 || pn != 0) m_bage = 0;
    else m_bage++;
    m_blink  = ((m_bage / BH) % 2 == 0);
    m_enable = (m_lvl[3] != 0 && nmode == 0);
    m_plus = pp; m_minus = pn; m_mode = nmode;
    for (int i = 0; i < 4; i++) begin
      s = h2[i]; h2[i] = h1[i]; h1[i] = raw[i];
      m_press[i] = 0;
      if (s != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = s; m_run[i] = 0; m_press[i] = s;
        end
      end else m_run[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    check_val("mode", int'(mode), m_mode);
    check_val("plus", int'(plus), m_plus);
    check_val("minus", int'(minus), m_minus);
    check_val("enable", int'(enable), m_enable);
    check_val("blink", int'(blink), m_blink);
    if (plus) plus_log.push_back(cyc);
    if (minus) minus_log.push_back(cyc);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic tap_mode();
    mode_btn = 1'b1; ticks(10);
    mode_btn = 1'b0; ticks(10);
  endtask

  initial begin
    int t0, sel, len, prev_blink;
    int tog[$];
    reset = 1'b1; mode_btn = 1'b0; plus_btn = 1'b0; minus_btn = 1'b0; run_sw = 1'b0;
    model_reset();
    ticks(3);
    check_val("rst_mode", int'(mode), 0);
    check_val("rst_blink", int'(blink), 1);
    check_val("rst_enable", int'(enable), 0);
    reset = 1'b0;
    ticks(2);

    // 1: run switch latency, plus ignored in RUN
    run_sw = 1'b1; t0 = cyc;
    for (int i = 0; i < 20 && !enable; i++) tick();
    check_val("enable_latency", cyc - t0, 7);
    plus_log.delete();
    plus_btn = 1'b1; ticks(10); plus_btn = 1'b0; ticks(10);
    check_val("run_plus_ignored", plus_log.size(), 0);

    // 2: mode sequence
    for (int k = 1; k <= 4; k++) begin
      tap_mode();
      check_val("mode_seq", int'(mode), k % 4);
      check_val("mode_seq_enable", int'(enable), (k % 4 == 0) ? 1 : 0);
    end

    // 3: glitch rejection and hold-to-repeat in SET_MIN
    tap_mode(); tap_mode();
    plus_log.delete();
    plus_btn = 1'b1; ticks(2); plus_btn = 1'b0; ticks(12);
    check_val("glitch_pulses", plus_log.size(), 0);
    t0 = cyc;
    plus_btn = 1'b1; ticks(40); plus_btn = 1'b0; ticks(30);
    check_val("repeat_count", plus_log.size(), 5);
    check_val("repeat_first", (plus_log.size() > 0) ? plus_log[0] - t0 : -1, 7);
    for (int i = 1; i < 5; i++)
      check_val("repeat_offset", (i < plus_log.size()) ? plus_log[i] - plus_log[0] : -1,
                RD + (i - 1) * RR);
    check_val("repeat_mode", int'(mode), 2);

    // 4: both buttons held in SET_SEC, then minus alone
    tap_mode(); tap_mode(); tap_mode();
    plus_log.delete(); minus_log.delete();
    plus_btn = 1'b1; minus_btn = 1'b1; ticks(30);
    plus_btn = 1'b0; minus_btn = 1'b0; ticks(12);
    check_val("both_plus", plus_log.size(), 0);
    check_val("both_minus", minus_log.size(), 0);
    minus_btn = 1'b1; ticks(10); minus_btn = 1'b0; ticks(12);
    check_val("minus_single", minus_log.size(), 1);
    check_val("minus_no_plus", plus_log.size(), 0);

    // 5: timeout from SET_HR with blink cadence
    tap_mode();
    mode_btn = 1'b1;
    for (int i = 0; i < 20 && mode != 2'b11; i++) tick();
    t0 = cyc; prev_blink = int'(blink);
    for (int i = 0; i < 150 && mode == 2'b11; i++) begin
      if (i == 3) mode_btn = 1'b0;
      tick();
      if (int'(blink) != prev_blink) tog.push_back(cyc - t0);
      prev_blink = int'(blink);
    end
    mode_btn = 1'b0;
    check_val("timeout_cycles", cyc - t0, TO);
    check_val("blink_toggles", tog.size(), 12);
    for (int i = 0; i < tog.size(); i++) check_val("blink_period", tog[i], BH * (i + 1));
    check_val("blink_run", int'(blink), 1);
    ticks(10);

    // 6: simultaneous mode/plus press, then reset during repeat
    tap_mode();
    plus_log.delete();
    mode_btn = 1'b1; plus_btn = 1'b1; ticks(10);
    mode_btn = 1'b0; plus_btn = 1'b0; ticks(10);
    check_val("simul_mode", int'(mode), 2);
    check_val("simul_plus", plus_log.size(), 0);
    plus_btn = 1'b1; ticks(30);
    check_val("pre_reset_pulses", plus_log.size(), 2);
    reset = 1'b1; tick(); reset = 1'b0;
    plus_log.delete();
    check_val("reset_mode", int'(mode), 0);
    ticks(30);
    check_val("post_reset_pulses", plus_log.size(), 0);
    plus_btn = 1'b0; ticks(10);

    // Random activity, checked cycle by cycle against the model
    for (int it = 0; it < 220; it++) begin
      sel = $urandom_range(0, 12);
      len = $urandom_range(1, 30);
      if (sel <= 3) mode_btn = ~mode_btn;
      else if (sel <= 6) plus_btn = ~plus_btn;
      else if (sel <= 9) minus_btn = ~minus_btn;
      else if (sel <= 11) run_sw = ~run_sw;
      else begin
        reset = 1'b1; ticks(len % 3 + 1); reset = 1'b0;
      end
      ticks(len);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
